// File: rtl/pc_sequencer_pkg.sv
// cpu_pkg: shared types, BHT init value and counter-update helper for the PC sequencer
package cpu_pkg;
   typedef enum logic [1:0] {BOOT, RUN, FLUSH} pcseq_state_t;
   typedef logic [1:0] bht_ctr_t;
   localparam bht_ctr_t BHT_INIT = 2'b01;
   function automatic bht_ctr_t bht_next(input bht_ctr_t c, input logic taken);
      return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
   endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: issue-stage and commit-side signals of the PC sequencer
interface pc_sequencer_if;
   logic        queue_full;
   logic        mispredicted;
   logic [31:0] pc_update;
   logic        commit_valid;
   logic        commit_is_branch;
   logic [31:0] commit_pc;
   logic        commit_result;
   logic [31:0] pipe_pc;
   logic        pipe_taken;
   logic        fetch_valid;
   logic        flush;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;
   modport master (
      output queue_full, mispredicted, pc_update, commit_valid, commit_is_branch, commit_pc, commit_result,
      input  pipe_pc, pipe_taken, fetch_valid, flush, branch_count, mispredict_count
   );
   modport slave (
      input  queue_full, mispredicted, pc_update, commit_valid, commit_is_branch, commit_pc, commit_result,
      output pipe_pc, pipe_taken, fetch_valid, flush, branch_count, mispredict_count
   );
endinterface

// File: rtl/pc_sequencer_bht.sv
// bht: 2-bit saturating branch history table, async read, sync update
module bht
   import cpu_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rd_pc,
   output logic        rd_taken,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic        wr_taken
);
   localparam int IW = $clog2(ENTRIES);
   bht_ctr_t ctr [ENTRIES];
   logic [IW-1:0] rd_idx, wr_idx;
   logic unused_pc_bits;
   assign rd_idx = rd_pc[IW+1:2];
   assign wr_idx = wr_pc[IW+1:2];
   assign unused_pc_bits = ^{rd_pc[31:IW+2], rd_pc[1:0], wr_pc[31:IW+2], wr_pc[1:0]};
   // Read sees the stored value, so a same-cycle update to this index shows next cycle
   assign rd_taken = ctr[rd_idx][1];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_INIT;
      end else if (wr_en) begin
         ctr[wr_idx] <= bht_next(ctr[wr_idx], wr_taken);
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC owner with stall, mispredict redirect, timed flush and BHT prediction
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          BHT_ENTRIES  = 64,
   parameter int          FLUSH_CYCLES = 2
) (
   input logic          clk,
   input logic          reset,
   pc_sequencer_if.slave sif
);
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   pcseq_state_t state;
   logic [CW-1:0] flush_cnt;
   logic br_commit;
   assign br_commit = sif.commit_valid & sif.commit_is_branch;
   assign sif.fetch_valid = (state == RUN) & ~sif.queue_full & ~sif.mispredicted;
   bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
      .clk      (clk),
      .reset    (reset),
      .rd_pc    (sif.pipe_pc),
      .rd_taken (sif.pipe_taken),
      .wr_en    (br_commit),
      .wr_pc    (sif.commit_pc),
      .wr_taken (sif.commit_result)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= BOOT;
         sif.pipe_pc          <= RESET_PC;
         sif.flush            <= 1'b0;
         flush_cnt            <= '0;
         sif.branch_count     <= '0;
         sif.mispredict_count <= '0;
      end else begin
         if (br_commit) sif.branch_count <= sif.branch_count + 32'd1;
         case (state)
            BOOT: state <= RUN;
            RUN: begin
               if (sif.mispredicted) begin
                  sif.pipe_pc          <= sif.pc_update;
                  state                <= FLUSH;
                  flush_cnt            <= CW'(FLUSH_CYCLES - 1);
                  sif.flush            <= 1'b1;
                  sif.mispredict_count <= sif.mispredict_count + 32'd1;
               end else if (!sif.queue_full) begin
                  sif.pipe_pc <= sif.pc_update;
               end
            end
            FLUSH: begin
               // flush drops together with the return to RUN, giving exactly FLUSH_CYCLES high cycles
               if (flush_cnt == '0) begin
                  state     <= RUN;
                  sif.flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus random traffic against a behavioural model
module tb_pc_sequencer;
   localparam int F = 2;
   localparam int N = 64;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   pc_sequencer_if sif();
   pc_sequencer #(.RESET_PC(32'h0), .BHT_ENTRIES(N), .FLUSH_CYCLES(F)) dut (
      .clk   (clk),
      .reset (reset),
      .sif   (sif)
   );
   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   logic [31:0] m_pc, m_bc, m_mc;
   bit m_boot;
   int m_fl;
   int m_bht [N];
   function automatic int idx(input logic [31:0] pc);
      return int'(pc[31:2]) % N;
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: boot lasts one cycle, a redirect owns the next F cycles, BHT is a plain saturating array
   always @(posedge clk) begin
      int k;
      if (reset) begin
         m_boot = 1;
         m_pc = 32'h0;
         m_fl = 0;
         m_bc = 0;
         m_mc = 0;
         foreach (m_bht[i]) m_bht[i] = 1;
      end else begin
         if (sif.commit_valid && sif.commit_is_branch) begin
            k = idx(sif.commit_pc);
            m_bht[k] = sif.commit_result ? ((m_bht[k] + 1 > 3) ? 3 : m_bht[k] + 1)
                                         : ((m_bht[k] - 1 < 0) ? 0 : m_bht[k] - 1);
            m_bc = m_bc + 1;
         end
         if (m_boot) m_boot = 0;
         else if (m_fl > 0) m_fl = m_fl - 1;
         else if (sif.mispredicted) begin
            m_pc = sif.pc_update;
            m_fl = F;
            m_mc = m_mc + 1;
         end else if (!sif.queue_full) m_pc = sif.pc_update;
      end
      chk_en = 1'b1;
   end
   always @(negedge clk) begin
      bit run;
      if (chk_en) begin
         run = !m_boot && m_fl == 0;
         check("pipe_pc", sif.pipe_pc, m_pc);
         check("fetch_valid", 32'(sif.fetch_valid), 32'(run && !sif.queue_full && !sif.mispredicted));
         check("flush", 32'(sif.flush), 32'(m_fl > 0));
         check("pipe_taken", 32'(sif.pipe_taken), 32'(m_bht[idx(m_pc)] >= 2));
         check("branch_count", sif.branch_count, m_bc);
         check("mispredict_count", sif.mispredict_count, m_mc);
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic seq();
      tick();
      sif.pc_update = sif.pipe_pc + 32'd4;
      #1;
   endtask
   initial begin
      sif.queue_full = 0; sif.mispredicted = 0; sif.pc_update = 0;
      sif.commit_valid = 0; sif.commit_is_branch = 0; sif.commit_pc = 0; sif.commit_result = 0;
      tick(); tick();
      reset = 0;
      sif.pc_update = 32'h4;
      #1;
      check("t1_boot_fv", 32'(sif.fetch_valid), 0);
      check("t1_boot_pc", sif.pipe_pc, 32'h0);
      for (int i = 0; i < 3; i++) begin
         seq();
         check("t1_seq_pc", sif.pipe_pc, 32'(i * 4));
         check("t1_seq_fv", 32'(sif.fetch_valid), 1);
      end
      seq(); seq();
      sif.queue_full = 1; #1;
      check("t2_hold_pc", sif.pipe_pc, 32'h10);
      check("t2_hold_fv", 32'(sif.fetch_valid), 0);
      seq();
      check("t2_hold2_pc", sif.pipe_pc, 32'h10);
      check("t2_hold2_fv", 32'(sif.fetch_valid), 0);
      seq();
      sif.queue_full = 0; #1;
      check("t2_resume_pc", sif.pipe_pc, 32'h10);
      check("t2_resume_fv", 32'(sif.fetch_valid), 1);
      seq();
      check("t2_adv_pc", sif.pipe_pc, 32'h14);
      sif.mispredicted = 1; sif.queue_full = 1; sif.pc_update = 32'h200; #1;
      check("t3_redir_fv", 32'(sif.fetch_valid), 0);
      tick();
      sif.pc_update = 32'h300; #1;
      check("t3_pc", sif.pipe_pc, 32'h200);
      check("t3_flush1", 32'(sif.flush), 1);
      check("t3_mc", sif.mispredict_count, 1);
      tick(); #1;
      check("t3_flush2", 32'(sif.flush), 1);
      check("t3_pc_hold", sif.pipe_pc, 32'h200);
      tick();
      sif.mispredicted = 0; sif.queue_full = 0; sif.pc_update = 32'h204; #1;
      check("t3_flush_end", 32'(sif.flush), 0);
      check("t3_fv_back", 32'(sif.fetch_valid), 1);
      check("t3_mc_once", sif.mispredict_count, 1);
      tick();
      sif.pc_update = 32'h40; #1;
      tick();
      sif.queue_full = 1;
      sif.commit_valid = 1; sif.commit_is_branch = 1; sif.commit_pc = 32'h40; sif.commit_result = 1; #1;
      check("t4_pc40", sif.pipe_pc, 32'h40);
      check("t4_pt_01", 32'(sif.pipe_taken), 0);
      tick(); #1;
      check("t4_pt_10", 32'(sif.pipe_taken), 1);
      tick(); #1;
      check("t4_pt_11", 32'(sif.pipe_taken), 1);
      tick();
      sif.commit_result = 0; #1;
      check("t4_pt_sat", 32'(sif.pipe_taken), 1);
      check("t4_bc", sif.branch_count, 3);
      tick(); #1;
      check("t5_pt_same_cycle", 32'(sif.pipe_taken), 1);
      tick();
      sif.commit_valid = 0; #1;
      check("t5_pt_next", 32'(sif.pipe_taken), 0);
      check("t5_bc", sif.branch_count, 5);
      sif.queue_full = 0; sif.mispredicted = 1; sif.pc_update = 32'h80;
      sif.commit_valid = 1; sif.commit_result = 1; #1;
      tick();
      sif.mispredicted = 0; sif.commit_valid = 0; reset = 1; #1;
      check("t6_flush_on", 32'(sif.flush), 1);
      tick();
      reset = 0; sif.pc_update = 32'h40; #1;
      check("t6_flush_abort", 32'(sif.flush), 0);
      check("t6_pc", sif.pipe_pc, 32'h0);
      check("t6_bc", sif.branch_count, 0);
      check("t6_mc", sif.mispredict_count, 0);
      tick(); tick(); #1;
      check("t6_bht_pc", sif.pipe_pc, 32'h40);
      check("t6_bht_init", 32'(sif.pipe_taken), 0);
      repeat (3000) begin
         tick();
         reset = ($urandom % 150) == 0;
         sif.queue_full = ($urandom % 4) == 0;
         sif.mispredicted = ($urandom % 6) == 0;
         sif.pc_update = ($urandom % 4 == 0) ? $urandom :
                         (($urandom % 2) ? sif.pipe_pc + 32'd4 : ($urandom & 32'h0000_00FC));
         sif.commit_valid = $urandom % 2;
         sif.commit_is_branch = ($urandom % 3) != 0;
         sif.commit_pc = ($urandom & 32'h0000_00FF) | (($urandom % 2) << 20);
         sif.commit_result = $urandom % 2;
      end
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
